// File: rtl/pts_shift_if.sv
// Load/shift/status bundle for pts_shift_engine.
// Defining PTS_ACK_SLOT_EN adds the ack_in/ack_ok pair.
interface pts_shift_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [CNT_W-1:0]  nbits;
  logic              shift_tick;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              ser_data_out;
  logic              ser_oe;
  logic              done;
`ifdef PTS_ACK_SLOT_EN
  logic              ack_in;
  logic              ack_ok;

  modport master (
    output load, data_in, nbits, shift_tick, abort, ack_in,
    input  ready, busy, ser_data_out, ser_oe, done, ack_ok
  );

  modport slave (
    input  load, data_in, nbits, shift_tick, abort, ack_in,
    output ready, busy, ser_data_out, ser_oe, done, ack_ok
  );
`else
  modport master (
    output load, data_in, nbits, shift_tick, abort,
    input  ready, busy, ser_data_out, ser_oe, done
  );

  modport slave (
    input  load, data_in, nbits, shift_tick, abort,
    output ready, busy, ser_data_out, ser_oe, done
  );
`endif
endinterface

// File: rtl/pts_shift_engine.sv
// Parallel-to-serial engine for the single-data-line I2C path.
// Optional receiver ACK slot enabled by defining PTS_ACK_SLOT_EN.
module pts_shift_engine #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  pts_shift_if.slave  bus
);

  if ((2 ** CNT_W) <= DATA_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow to count DATA_W bits");
  end

  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DATA_W);

`ifdef PTS_ACK_SLOT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ACK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  sreg;
  logic [DATA_W-1:0]  sreg_load;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   n_eff;
  logic [CNT_W-1:0]   shamt;
  logic               cur_bit;
  logic               accept;
  logic               advance;
  logic               done_nxt;
  logic               done_q;
  logic               ready_c;
  logic               oe_c;
  logic               sdo_c;
`ifdef PTS_ACK_SLOT_EN
  logic               ack_capture;
  logic               ack_ok_q;
`endif

  // Zero or oversize counts fall back to a full word.
  always_comb begin
    n_eff = bus.nbits;
    if ((bus.nbits == '0) || (bus.nbits > FULL_N)) begin
      n_eff = FULL_N;
    end
    shamt = FULL_N - n_eff;
  end

  // MSB-first left-aligns bit N-1 at the top so shifting left walks down to bit 0.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_load = bus.data_in << shamt;
      cur_bit   = sreg[DATA_W-1];
    end else begin
      sreg_load = bus.data_in;
      cur_bit   = sreg[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort wins over tick and load in every state
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    ready_c   = 1'b0;
    oe_c      = 1'b0;
    sdo_c     = 1'b1;
`ifdef PTS_ACK_SLOT_EN
    ack_capture = 1'b0;
`endif
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.load && !bus.abort) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        oe_c  = 1'b1;
        sdo_c = cur_bit;
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.shift_tick) begin
          advance = 1'b1;
          if (remaining == CNT_W'(1)) begin
`ifdef PTS_ACK_SLOT_EN
            state_nxt = ACK;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end
        end
      end
`ifdef PTS_ACK_SLOT_EN
      ACK: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.shift_tick) begin
          ack_capture = 1'b1;
          done_nxt    = 1'b1;
          state_nxt   = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (accept) begin
        sreg      <= sreg_load;
        remaining <= n_eff;
      end else if (advance) begin
        remaining <= remaining - CNT_W'(1);
        if (MSB_FIRST) begin
          sreg <= {sreg[DATA_W-2:0], 1'b0};
        end else begin
          sreg <= {1'b0, sreg[DATA_W-1:1]};
        end
      end
    end
  end

`ifdef PTS_ACK_SLOT_EN
  // ACK is active-low on the line; the flag survives aborts and clears on the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_ok_q <= 1'b0;
    end else if (accept) begin
      ack_ok_q <= 1'b0;
    end else if (ack_capture) begin
      ack_ok_q <= ~bus.ack_in;
    end
  end

  assign bus.ack_ok = ack_ok_q;
`endif

  assign bus.ready        = ready_c;
  assign bus.busy         = ~ready_c;
  assign bus.ser_oe       = oe_c;
  assign bus.ser_data_out = sdo_c;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pts_shift_engine.sv
// Bench for pts_shift_engine: MSB-first and LSB-first instances driven in lockstep.
// Honours PTS_ACK_SLOT_EN when the build defines it.
`timescale 1ns/1ps
module tb_pts_shift_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [4:0]  nbits = '0;
  logic        shift_tick = 1'b0;
  logic        abort = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
`ifdef PTS_ACK_SLOT_EN
  logic        ack_in = 1'b1;
  logic        ack_next = 1'b0;
  logic        exp_ack = 1'b0;
`endif

  always #5 clk = ~clk;

  pts_shift_if #(.DATA_W(16), .CNT_W(5)) bus_m ();
  pts_shift_if #(.DATA_W(16), .CNT_W(5)) bus_l ();

  assign bus_m.load = load;        assign bus_l.load = load;
  assign bus_m.data_in = data_in;  assign bus_l.data_in = data_in;
  assign bus_m.nbits = nbits;      assign bus_l.nbits = nbits;
  assign bus_m.shift_tick = shift_tick;
  assign bus_l.shift_tick = shift_tick;
  assign bus_m.abort = abort;      assign bus_l.abort = abort;
`ifdef PTS_ACK_SLOT_EN
  assign bus_m.ack_in = ack_in;    assign bus_l.ack_in = ack_in;
`endif

  pts_shift_engine #(.DATA_W(16), .CNT_W(5), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  pts_shift_engine #(.DATA_W(16), .CNT_W(5), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int n);
    return ((n == 0) || (n > 16)) ? 16 : n;
  endfunction

  // k-th transmitted bit of the low n bits of d, in the requested order
  function automatic logic exp_bit(input logic [15:0] d, input int n, input int k, input bit msb);
    int idx;
    idx = msb ? (n - 1 - k) : k;
    return logic'((d >> idx) & 16'h1);
  endfunction

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".m.ready"}, bus_m.ready, 1'b1);
    chk({tag, ".m.busy"},  bus_m.busy, 1'b0);
    chk({tag, ".m.oe"},    bus_m.ser_oe, 1'b0);
    chk({tag, ".m.sdo"},   bus_m.ser_data_out, 1'b1);
    chk({tag, ".m.done"},  bus_m.done, exp_done);
    chk({tag, ".l.ready"}, bus_l.ready, 1'b1);
    chk({tag, ".l.oe"},    bus_l.ser_oe, 1'b0);
    chk({tag, ".l.done"},  bus_l.done, exp_done);
`ifdef PTS_ACK_SLOT_EN
    chk({tag, ".m.ack_ok"}, bus_m.ack_ok, exp_ack);
    chk({tag, ".l.ack_ok"}, bus_l.ack_ok, exp_ack);
`endif
  endtask

  task automatic chk_shift(input string tag, input logic [15:0] d, input int n, input int k);
    chk({tag, ".m.busy"}, bus_m.busy, 1'b1);
    chk({tag, ".m.oe"},   bus_m.ser_oe, 1'b1);
    chk({tag, ".m.sdo"},  bus_m.ser_data_out, exp_bit(d, n, k, 1'b1));
    chk({tag, ".m.done"}, bus_m.done, 1'b0);
    chk({tag, ".l.ready"}, bus_l.ready, 1'b0);
    chk({tag, ".l.oe"},   bus_l.ser_oe, 1'b1);
    chk({tag, ".l.sdo"},  bus_l.ser_data_out, exp_bit(d, n, k, 1'b0));
`ifdef PTS_ACK_SLOT_EN
    chk({tag, ".m.ack_ok"}, bus_m.ack_ok, exp_ack);
`endif
  endtask

  task automatic start(input logic [15:0] d, input int n);
    load = 1'b1;
    data_in = d;
    nbits = 5'(n);
    step();
    load = 1'b0;
    data_in = 16'($urandom);
    nbits = 5'($urandom);
`ifdef PTS_ACK_SLOT_EN
    exp_ack = 1'b0;
`endif
  endtask

  // Walk one accepted transfer to completion; optionally load the next word in the done cycle.
  task automatic shift_out(input logic [15:0] d, input int n, input bit gaps, input bit junk,
                           input bit chain, input logic [15:0] nd, input int nn);
    int ne;
    ne = eff(n);
    for (int k = 0; k < ne; k++) begin
      chk_shift("bit", d, ne, k);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          if (junk) begin
            load = 1'b1;
            data_in = ~d;
            nbits = 5'($urandom);
          end
          step();
          load = 1'b0;
          chk_shift("hold", d, ne, k);
        end
      end
      shift_tick = 1'b1;
      step();
      shift_tick = 1'b0;
    end
`ifdef PTS_ACK_SLOT_EN
    chk("ackslot.m.oe",   bus_m.ser_oe, 1'b0);
    chk("ackslot.m.busy", bus_m.busy, 1'b1);
    chk("ackslot.m.done", bus_m.done, 1'b0);
    chk("ackslot.l.oe",   bus_l.ser_oe, 1'b0);
    ack_in = ack_next;
    shift_tick = 1'b1;
    step();
    shift_tick = 1'b0;
    ack_in = 1'b1;
    exp_ack = ~ack_next;
`endif
    chk_idle("done", 1'b1);
    if (chain) begin
      load = 1'b1;
      data_in = nd;
      nbits = 5'(nn);
      step();
      load = 1'b0;
`ifdef PTS_ACK_SLOT_EN
      exp_ack = 1'b0;
`endif
    end else begin
      step();
      chk_idle("after", 1'b0);
    end
  endtask

  initial begin : main
    logic [15:0] d, nd;
    int n, nn;
    bit chain;

    #3;
    chk_idle("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("reset_rel", 1'b0);

    // ticks in IDLE and an aborted load are both ignored
    shift_tick = 1'b1;
    step();
    step();
    shift_tick = 1'b0;
    chk_idle("idle_tick", 1'b0);
    load = 1'b1;
    abort = 1'b1;
    step();
    load = 1'b0;
    abort = 1'b0;
    chk_idle("idle_abort_load", 1'b0);

`ifdef PTS_ACK_SLOT_EN
    ack_next = 1'b0;
`endif
    start(16'hA5C3, 0);
    shift_out(16'hA5C3, 0, 1'b0, 1'b0, 1'b0, 16'h0, 0);

`ifdef PTS_ACK_SLOT_EN
    ack_next = 1'b1;
`endif
    start(16'hFF3C, 8);
    shift_out(16'hFF3C, 8, 1'b1, 1'b1, 1'b0, 16'h0, 0);

    // abort together with the 5th tick
    start(16'h9D71, 16);
    for (int k = 0; k < 4; k++) begin
      chk_shift("abort_pre", 16'h9D71, 16, k);
      shift_tick = 1'b1;
      step();
      shift_tick = 1'b0;
    end
    chk_shift("abort_pre", 16'h9D71, 16, 4);
    shift_tick = 1'b1;
    abort = 1'b1;
    step();
    shift_tick = 1'b0;
    abort = 1'b0;
    chk_idle("abort", 1'b0);
    step();
    chk_idle("abort_nodone", 1'b0);
    start(16'h0001, 16);
    shift_out(16'h0001, 16, 1'b0, 1'b0, 1'b0, 16'h0, 0);

    // back-to-back: second word loaded in the done cycle, ticks on adjacent cycles
    start(16'h000B, 4);
    shift_out(16'h000B, 4, 1'b0, 1'b0, 1'b1, 16'hC35A, 8);
    shift_out(16'hC35A, 8, 1'b0, 1'b0, 1'b0, 16'h0, 0);

    // reset asserted mid-transfer takes effect without a clock edge
    start(16'h7E81, 12);
    repeat (3) begin
      shift_tick = 1'b1;
      step();
      shift_tick = 1'b0;
    end
    chk_shift("pre_rst", 16'h7E81, 12, 3);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef PTS_ACK_SLOT_EN
    exp_ack = 1'b0;
`endif
    chk_idle("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("rst_nodone", 1'b0);

    // randomized words, counts, gaps, junk loads and chaining
    d = 16'($urandom);
    n = $urandom_range(0, 31);
    start(d, n);
    for (int i = 0; i < 10; i++) begin
      chain = (i < 9) && ($urandom_range(0, 1) == 1);
      nd = 16'($urandom);
      nn = $urandom_range(0, 31);
`ifdef PTS_ACK_SLOT_EN
      ack_next = 1'($urandom);
`endif
      shift_out(d, n, 1'b1, 1'b1, chain, nd, nn);
      if (!chain && (i < 9)) begin
        start(nd, nn);
      end
      d = nd;
      n = nn;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pts_shift_engine.md
Name: pts_shift_engine

Overview:
- Clocked, parametrised parallel-to-serial engine for the single-data-line I2C path.
- Accepts a parallel word through a load handshake and shifts out a programmable number of bits, one per `shift_tick` strobe.
- `shift_tick` comes from the bus timing block (one pulse per SCL low phase).
- Drives the data line through an explicit output enable, so the pad/tristate block owns the line. Reports completion and, optionally, the receiver ACK.

Parameters:
- DATA_W, 16, width of the parallel word.
- CNT_W, 5, width of `nbits` and of the internal bit counter; must satisfy 2^CNT_W > DATA_W.
- MSB_FIRST, 1, 1 = send the highest selected bit first, 0 = send bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  request to start a transfer; accepted only when `ready`=1.
- data_in  input  DATA_W  parallel word, sampled on the accepted `load`.
- nbits  input  CNT_W  bits to send, sampled with `load`; 0 or >DATA_W means DATA_W.
- shift_tick  input  1  single-cycle strobe; advances one bit.
- abort  input  1  synchronous cancel of the current transfer.
- ready  output  1  engine idle, can accept `load`.
- busy  output  1  transfer in progress (= ~`ready`).
- ser_data_out  output  1  serial bit to the pad block.
- ser_oe  output  1  1 = drive the line with `ser_data_out`, 0 = release it.
- done  output  1  one-cycle pulse when a transfer completes normally.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, `ready`=1, `busy`=0, `ser_oe`=0, `ser_data_out`=1, `done`=0.
  - Shift register and counter cleared.
- States: IDLE, SHIFT (plus ACK when the macro is defined).
- IDLE:
  - `ser_oe`=0, `ser_data_out`=1.
  - `load`=1 and `abort`=0 → capture the word and count N = effective `nbits`; enter SHIFT on the next edge.
  - The transmitted bits are `data_in[N-1:0]`:
    - MSB_FIRST=1: bit N-1 first, ending with bit 0.
    - MSB_FIRST=0: bit 0 first, ending with bit N-1.
- SHIFT:
  - `ser_oe`=1 and `ser_data_out` = current bit, from the first cycle in SHIFT (one-cycle load latency).
  - Each `shift_tick` advances to the next bit on that edge and decrements the remaining count.
  - A `shift_tick` while remaining=1 ends the transfer:
    - Next cycle: state=IDLE, `ser_oe`=0, `done`=1 for exactly one cycle.
- `load` while `busy` is ignored; no queueing. `shift_tick` in IDLE is ignored.
- `abort`:
  - Any non-IDLE state → IDLE on the next edge, with no `done` pulse.
  - `abort` has priority over a simultaneous `shift_tick` or `load`.
- `done` and a new `load` in the same cycle: `ready` is already 1 in the `done` cycle, so the load is accepted. Back-to-back transfers lose no cycles.
- Reset asserted mid-transfer: all outputs go immediately to their reset values; no `done`.

Optional Feature:
- Macro PTS_ACK_SLOT_EN. Adds:
  - input `ack_in` (1 bit);
  - output `ack_ok` (1 bit, reset 0);
  - state ACK.
- When defined:
  - The last-bit `shift_tick` moves SHIFT → ACK instead of SHIFT → IDLE.
  - In ACK: `ser_oe`=0. The next `shift_tick` samples `ack_in`, sets `ack_ok` = ~`ack_in` (low = ACK), and goes to IDLE with the `done` pulse.
  - `ack_ok` holds until the next accepted `load`, which clears it.
  - `abort` in ACK → IDLE, `ack_ok` unchanged.
- When undefined: no ACK state, no `ack_in`/`ack_ok` ports; behaviour exactly as above.

Test Plan:
- Reset, then `load` `data_in`=16'hA5C3, `nbits`=0, MSB_FIRST=1, 16 ticks → serial sequence 1010_0101_1100_0011; `ser_oe`=1 throughout; `done` one cycle after the 16th tick; `ready`=1 again.
- `nbits`=8, `data_in`=16'hFF3C, MSB_FIRST=0 → bits 0,0,1,1,1,1,0,0 (from 8'h3C, LSB first); high byte never appears; `done` after the 8th tick.
- `load` pulsed while `busy`, and `shift_tick` in IDLE → no effect; sequence and tick count unchanged.
- `abort` together with the 5th tick of a 16-bit transfer → IDLE next cycle, `ser_oe`=0, no `done`; next `load` of 16'h0001 transfers correctly.
- New `load` in the `done` cycle → second transfer starts next cycle; bit 0 of the first word and the first bit of the second are on adjacent ticks.
- PTS_ACK_SLOT_EN defined, 8-bit transfer, `ack_in`=0 on the 9th tick → `ser_oe`=0 during the ACK slot, `ack_ok`=1, `done` once. Repeat with `ack_in`=1 → `ack_ok`=0.
